dummy_mig_lat: RTL and testbench

Parametrised behavioural stand-in for the MIG 7-series user (app) interface, the next generation of the fixed dummy DRAM model. It sits behind `dram_top` on the `mclk` domain and replaces the DDR3 controller for FPGA-less simulation and DRAM-free FPGA builds. It adds configurable memory depth, configurable read latency through a valid/data pipeline, a write-data FIFO with command/data decoupling, and optional refresh back-pressure.

---
 rtl/dummy_mig_lat.sv | 163 ++++++++++++++++
 tb/tb_dummy_mig_lat.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_mig_lat.sv
// rtl/dummy_mig_lat.sv - behavioural MIG app-interface stand-in with read latency pipeline; refresh back-pressure under DUMMY_MIG_REFRESH_EN
module dummy_mig_lat #(
    parameter int AWIDTH        = 28,
    parameter int DEPTH_LOG2    = 10,
    parameter int RD_LAT        = 8,
    parameter int WF_DEPTH_LOG2 = 2,
    parameter int REF_PERIOD    = 64,
    parameter int REF_BUSY      = 4
) (
    input  logic              mclk,
    input  logic              mrst_n,
    input  logic [AWIDTH-1:0] app_addr,
    input  logic [2:0]        app_cmd,
    input  logic              app_en,
    output logic              app_rdy,
    input  logic [127:0]      app_wdf_data,
    input  logic [15:0]       app_wdf_mask,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    output logic              app_wdf_rdy,
    output logic [127:0]      app_rd_data,
    output logic              app_rd_data_end,
    output logic              app_rd_data_valid
);
    localparam int WF_DEPTH = 1 << WF_DEPTH_LOG2;
    localparam int PIPE     = RD_LAT - 1;

    logic [127:0] mem     [0:(1<<DEPTH_LOG2)-1];
    logic [127:0] wf_data [0:WF_DEPTH-1];
    logic [15:0]  wf_mask [0:WF_DEPTH-1];

    logic [WF_DEPTH_LOG2:0]  wf_wr_ptr_q, wf_wr_ptr_d;
    logic [WF_DEPTH_LOG2:0]  wf_rd_ptr_q, wf_rd_ptr_d;
    logic                    pend_q, pend_d;
    logic [DEPTH_LOG2-1:0]   pend_idx_q, pend_idx_d;
    logic [PIPE-1:0]         pipe_vld_q, pipe_vld_d;
    logic [127:0]            pipe_dat_q [PIPE];
    logic [127:0]            pipe_dat_d [PIPE];
    logic                    rd_vld_q, rd_vld_d;
    logic [127:0]            rd_dat_q, rd_dat_d;

    logic                    refresh_busy;
    logic                    wf_empty, wf_full, wf_push;
    logic                    acc_wr, acc_rd, commit;
    logic [DEPTH_LOG2-1:0]   cmd_idx, commit_idx;
    logic [127:0]            head_data, merged;
    logic [15:0]             head_mask;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{app_addr[2:0], app_addr[AWIDTH-1:DEPTH_LOG2+3]};

`ifdef DUMMY_MIG_REFRESH_EN
    localparam int REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;

    // free-running refresh interval counter, wraps at REF_PERIOD-1
    always_comb begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        if (ref_cnt_q == REF_W'(REF_PERIOD - 1)) begin
            ref_cnt_d = '0;
        end
    end

    // refresh counter register
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
        end
    end

    assign refresh_busy = (ref_cnt_q >= REF_W'(REF_PERIOD - REF_BUSY));
`else
    assign refresh_busy = 1'b0;
`endif

    assign wf_empty    = (wf_wr_ptr_q == wf_rd_ptr_q);
    assign wf_full     = ((wf_wr_ptr_q - wf_rd_ptr_q) == (WF_DEPTH_LOG2+1)'(WF_DEPTH));
    assign app_rdy     = ~pend_q & ~refresh_busy;
    assign app_wdf_rdy = ~wf_full;
    assign app_rd_data       = rd_dat_q;
    assign app_rd_data_valid = rd_vld_q;
    assign app_rd_data_end   = rd_vld_q;

    // command decode, write commit (immediate or deferred) and byte-mask merge
    always_comb begin
        cmd_idx    = app_addr[DEPTH_LOG2+2:3];
        acc_wr     = app_en & app_rdy & (app_cmd == 3'b000);
        acc_rd     = app_en & app_rdy & (app_cmd == 3'b001);
        wf_push    = app_wdf_wren & app_wdf_end & ~wf_full;
        commit     = ~wf_empty & (pend_q | acc_wr);
        commit_idx = pend_q ? pend_idx_q : cmd_idx;
        head_data  = wf_data[wf_rd_ptr_q[WF_DEPTH_LOG2-1:0]];
        head_mask  = wf_mask[wf_rd_ptr_q[WF_DEPTH_LOG2-1:0]];
        merged     = mem[commit_idx];
        for (int i = 0; i < 16; i++) begin
            if (!head_mask[i]) begin
                merged[8*i +: 8] = head_data[8*i +: 8];
            end
        end
        wf_wr_ptr_d = wf_wr_ptr_q + (WF_DEPTH_LOG2+1)'(wf_push);
        wf_rd_ptr_d = wf_rd_ptr_q + (WF_DEPTH_LOG2+1)'(commit);
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        if (pend_q && !wf_empty) begin
            pend_d = 1'b0;
        end else if (acc_wr && wf_empty) begin
            pend_d     = 1'b1;
            pend_idx_d = cmd_idx;
        end
    end

    // read-return shift pipeline feeding the registered outputs
    always_comb begin
        pipe_vld_d[0] = acc_rd;
        pipe_dat_d[0] = mem[cmd_idx];
        for (int i = 1; i < PIPE; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end
        rd_vld_d = pipe_vld_q[PIPE-1];
        rd_dat_d = pipe_dat_q[PIPE-1];
    end

    // control, pipeline and output registers
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            wf_wr_ptr_q <= '0;
            wf_rd_ptr_q <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < PIPE; i++) begin
                pipe_dat_q[i] <= '0;
            end
            rd_vld_q    <= 1'b0;
            rd_dat_q    <= '0;
        end else begin
            wf_wr_ptr_q <= wf_wr_ptr_d;
            wf_rd_ptr_q <= wf_rd_ptr_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            pipe_vld_q  <= pipe_vld_d;
            for (int i = 0; i < PIPE; i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
            rd_vld_q    <= rd_vld_d;
            rd_dat_q    <= rd_dat_d;
        end
    end

    // array and write-FIFO storage; neither is reset
    always_ff @(posedge mclk) begin
        if (commit) begin
            mem[commit_idx] <= merged;
        end
        if (wf_push) begin
            wf_data[wf_wr_ptr_q[WF_DEPTH_LOG2-1:0]] <= app_wdf_data;
            wf_mask[wf_wr_ptr_q[WF_DEPTH_LOG2-1:0]] <= app_wdf_mask;
        end
    end
endmodule

// File: tb/tb_dummy_mig_lat.sv
// tb/tb_dummy_mig_lat.sv - randomized self-checking bench for dummy_mig_lat against a queue-based memory model
module tb_dummy_mig_lat;
    localparam int AWIDTH        = 28;
    localparam int DEPTH_LOG2    = 10;
    localparam int RD_LAT        = 8;
    localparam int WF_DEPTH_LOG2 = 2;
    localparam int WF_DEPTH      = 1 << WF_DEPTH_LOG2;
    localparam int REF_PERIOD    = 64;
    localparam int REF_BUSY      = 4;

    logic              mclk = 1'b0;
    logic              mrst_n = 1'b0;
    logic [AWIDTH-1:0] app_addr = '0;
    logic [2:0]        app_cmd = '0;
    logic              app_en = 1'b0;
    logic              app_rdy;
    logic [127:0]      app_wdf_data = '0;
    logic [15:0]       app_wdf_mask = '0;
    logic              app_wdf_wren = 1'b0;
    logic              app_wdf_end = 1'b0;
    logic              app_wdf_rdy;
    logic [127:0]      app_rd_data;
    logic              app_rd_data_end;
    logic              app_rd_data_valid;

    dummy_mig_lat #(
        .AWIDTH(AWIDTH), .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT),
        .WF_DEPTH_LOG2(WF_DEPTH_LOG2), .REF_PERIOD(REF_PERIOD), .REF_BUSY(REF_BUSY)
    ) dut (
        .mclk(mclk), .mrst_n(mrst_n), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
        .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 mclk = ~mclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct { logic [127:0] d; logic [15:0] m; } beat_t;
    typedef struct { int due; logic [127:0] d; logic [127:0] k; } rd_t;

    beat_t        wfq[$];
    rd_t          rq[$];
    logic [127:0] m_mem   [int];
    logic [15:0]  m_known [int];
    bit           m_pend = 1'b0;
    int           m_pidx = 0;
    int           cyc = 0;
    int           m_ref = 0;

    function automatic bit m_busy();
`ifdef DUMMY_MIG_REFRESH_EN
        return m_ref >= REF_PERIOD - REF_BUSY;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void m_write(int idx, beat_t b);
        logic [127:0] v;
        logic [15:0]  k;
        v = m_mem.exists(idx) ? m_mem[idx] : '0;
        k = m_known.exists(idx) ? m_known[idx] : '0;
        for (int i = 0; i < 16; i++) begin
            if (!b.m[i]) begin
                v[8*i +: 8] = b.d[8*i +: 8];
                k[i] = 1'b1;
            end
        end
        m_mem[idx] = v;
        m_known[idx] = k;
    endfunction

    task automatic check_outputs();
        rd_t r;
        chk("app_rdy", 128'(app_rdy), 128'(!m_pend && !m_busy()));
        chk("app_wdf_rdy", 128'(app_wdf_rdy), 128'(wfq.size() < WF_DEPTH));
        chk("rd_data_end", 128'(app_rd_data_end), 128'(app_rd_data_valid));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            chk("rd_valid", 128'(app_rd_data_valid), 128'd1);
            chk("rd_data", app_rd_data & r.k, r.d & r.k);
        end else begin
            chk("rd_valid_idle", 128'(app_rd_data_valid), 128'd0);
        end
    endtask

    task automatic step(input bit en, input logic [2:0] cmd, input logic [AWIDTH-1:0] addr,
                        input bit wren, input bit wend, input logic [127:0] d, input logic [15:0] m);
        bit    rdy, wrdy, acc;
        int    idx;
        beat_t b;
        rd_t   r;
        app_en = en; app_cmd = cmd; app_addr = addr;
        app_wdf_wren = wren; app_wdf_end = wend; app_wdf_data = d; app_wdf_mask = m;
        rdy  = !m_pend && !m_busy();
        wrdy = wfq.size() < WF_DEPTH;
        acc  = en && rdy;
        idx  = int'(addr[DEPTH_LOG2+2:3]);
        if (acc && cmd == 3'b000) begin
            if (wfq.size() != 0) begin
                b = wfq.pop_front();
                m_write(idx, b);
            end else begin
                m_pend = 1'b1;
                m_pidx = idx;
            end
        end else if (m_pend && wfq.size() != 0) begin
            b = wfq.pop_front();
            m_write(m_pidx, b);
            m_pend = 1'b0;
        end
        if (acc && cmd == 3'b001) begin
            r.due = cyc + RD_LAT;
            r.d = m_mem.exists(idx) ? m_mem[idx] : '0;
            r.k = '0;
            if (m_known.exists(idx)) begin
                for (int i = 0; i < 16; i++) r.k[8*i +: 8] = {8{m_known[idx][i]}};
            end
            rq.push_back(r);
        end
        if (wren && wend && wrdy) begin
            b.d = d;
            b.m = m;
            wfq.push_back(b);
        end
        @(posedge mclk);
        #1;
        cyc++;
        m_ref = (m_ref + 1) % REF_PERIOD;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'b000, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic push(input logic [127:0] d, input logic [15:0] m);
        step(1'b0, 3'b000, '0, 1'b1, 1'b1, d, m);
    endtask

    task automatic cmd(input logic [2:0] c, input logic [AWIDTH-1:0] a);
        step(1'b1, c, a, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        mrst_n = 1'b0;
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        wfq.delete();
        rq.delete();
        m_pend = 1'b0;
        m_ref = 0;
        repeat (n) begin
            @(posedge mclk);
            #1;
            cyc++;
            chk("rst_app_rdy", 128'(app_rdy), 128'd1);
            chk("rst_wdf_rdy", 128'(app_wdf_rdy), 128'd1);
            chk("rst_valid", 128'(app_rd_data_valid), 128'd0);
            chk("rst_end", 128'(app_rd_data_end), 128'd0);
            chk("rst_data", app_rd_data, 128'd0);
        end
        mrst_n = 1'b1;
    endtask

    initial begin
        logic [AWIDTH-1:0] a;
        logic [127:0]      d;
        logic [15:0]       m;
        bit                en, wren, wend;
        logic [2:0]        c;
        int                sel;

        do_reset(3);

        // known contents for indices 0..15
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            push(d, 16'h0000);
            cmd(3'b000, AWIDTH'(i * 8));
        end
        idle(2);

        // full write then read one cycle later
        push(128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h0000);
        cmd(3'b000, AWIDTH'('h08));
        cmd(3'b001, AWIDTH'('h08));
        idle(RD_LAT + 2);

        // partial write with byte mask
        push('0, 16'h0000);
        cmd(3'b000, AWIDTH'('h10));
        push({128{1'b1}}, 16'hFF00);
        cmd(3'b000, AWIDTH'('h10));
        cmd(3'b001, AWIDTH'('h10));
        idle(RD_LAT + 2);

        // write command ahead of its data
        cmd(3'b000, AWIDTH'('h20));
        idle(2);
        push(128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 16'h0000);
        idle(2);
        cmd(3'b001, AWIDTH'('h20));
        idle(RD_LAT + 2);

        // command and data in the same cycle on an empty FIFO
        step(1'b1, 3'b000, AWIDTH'('h28), 1'b1, 1'b1, 128'hA5A5, 16'h0000);
        idle(1);
        cmd(3'b001, AWIDTH'('h28));
        idle(RD_LAT + 2);

        // overfill the FIFO, then drain in order
        for (int i = 0; i < 5; i++) push(128'(64'h1111_0000 + i), 16'h0000);
        for (int i = 0; i < 4; i++) cmd(3'b000, AWIDTH'('h40 + 8 * i));
        for (int i = 0; i < 4; i++) cmd(3'b001, AWIDTH'('h40 + 8 * i));
        idle(RD_LAT + 2);

        // back-to-back reads, then reads cut off by reset
        for (int i = 0; i < 4; i++) cmd(3'b001, AWIDTH'(8 * i));
        idle(RD_LAT + 2);
        for (int i = 0; i < 4; i++) cmd(3'b001, AWIDTH'(8 * i));
        idle(2);
        do_reset(2);
        idle(RD_LAT + 4);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(2);
                continue;
            end
            en = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            c = (sel < 4) ? 3'b000 : (sel < 9) ? 3'b001 : 3'($urandom_range(2, 7));
            a = AWIDTH'($urandom);
            a[DEPTH_LOG2+2:3] = DEPTH_LOG2'($urandom_range(0, 15));
            wren = ($urandom_range(0, 1) == 1);
            wend = wren && ($urandom_range(0, 7) != 0);
            d = {$urandom, $urandom, $urandom, $urandom};
            m = ($urandom_range(0, 1) == 1) ? 16'h0000 : 16'($urandom);
            step(en, c, a, wren, wend, d, m);
        end
        idle(RD_LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
